mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for multiply ops (legal range 1..31).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for divide ops (legal range 1..31).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  issue strobe; op, srcA and srcB are sampled at the same edge.
REQ-006 SHALL have port op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
REQ-007 SHALL have port srcA  input  32  operand A (dividend / multiplicand / move source).
REQ-008 SHALL have port srcB  input  32  operand B (divisor / multiplier).
REQ-009 SHALL have port busy  output  1  high while a multiply or divide is in flight.
REQ-010 SHALL have port hi  output  32  architectural HI register.
REQ-011 SHALL have port lo  output  32  architectural LO register.

Function
REQ-012 SHALL implement states IDLE, MUL and DIV, plus a 5-bit down-counter.
REQ-013 In IDLE, start with op 0/1 SHALL latch srcA/srcB/op, load the counter with MULT_CYCLES and go to MUL.
REQ-014 In IDLE, start with op 2/3 SHALL latch srcA/srcB/op, load the counter with DIV_CYCLES and go to DIV.
REQ-015 busy SHALL equal (state != IDLE), a registered value with no combinational path from start.
REQ-016 Cycle timing: for start accepted at edge E0, busy SHALL be 1 for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES). At the Nth edge after E0, hi/lo SHALL update and busy SHALL fall together.
REQ-017 Results SHALL be computed from the latched operands only; srcA/srcB changes after E0 SHALL have no effect.
REQ-018 MULT SHALL form the signed 64-bit product; MULTU the unsigned 64-bit product; {hi,lo} = product.
REQ-019 DIV SHALL truncate toward zero: lo = quotient, hi = remainder, remainder sign equal to the dividend sign.
REQ-020 DIVU SHALL give lo = unsigned quotient, hi = unsigned remainder.
REQ-021 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-022 DIV/DIVU with srcB=0 SHALL still take DIV_CYCLES busy cycles and SHALL leave hi/lo unchanged at completion.
REQ-023 In IDLE, start with op 4 (MTHI) SHALL write hi=srcA at that edge; op 5 (MTLO) SHALL write lo=srcA. busy SHALL stay 0.
REQ-024 In IDLE, start with op 6/7 SHALL change no state.
REQ-025 While busy=1, start SHALL be ignored for all ops, including MTHI/MTLO. The issuing stage must stall.
REQ-026 Start in the same cycle that busy falls (the completion edge) SHALL be ignored; start is accepted only when busy=0 at the sampling edge.
REQ-027 hi/lo SHALL be stable and hold their values while busy=1; old values remain readable until the completion edge.
REQ-028 Arithmetic SHALL be width-exact: 64-bit products, 32-bit quotient/remainder, no truncation of intermediate sign.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state=IDLE, counter=0, busy=0, hi=0, lo=0 and clear the latched operands.
REQ-030 Reset asserted mid-operation SHALL abort the operation; no result SHALL be written after reset_n returns to 1.
REQ-031 The first start SHALL be accepted at the first rising edge after reset_n deasserts.

Verification
REQ-032 MULT srcA=0xFFFFFFFE (-2), srcB=3 -> busy 1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
REQ-033 MULTU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/0 -> hi/lo unchanged after 10 cycles.
REQ-035 MTHI srcA=0x12345678 while idle -> hi=0x12345678 at the next edge, busy stays 0. The same op issued during a DIV -> ignored, and hi still holds 0x12345678 until completion.
REQ-036 Start a DIV, pulse reset_n low at cycle 4, release it -> busy=0, hi=lo=0 throughout, no late writeback. A MULT 2*3 issued right after reset -> lo=6 after 5 cycles.
REQ-037 Start a MULT, hold start high with op=MULT and different operands for the whole busy window -> exactly one result (from the first operands); a second op is accepted only at the edge after busy falls.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: holds the architectural HI/LO registers and models
// multi-cycle MULT/DIV latency with a down-counter, writing results back on completion.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    localparam logic [4:0] MulCnt = 5'(MULT_CYCLES);
    localparam logic [4:0] DivCnt = 5'(DIV_CYCLES);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;

    logic [63:0] ext_a, ext_b, prod;
    logic        div_signed, neg_a, neg_b;
    logic [31:0] mag_a, mag_b, uquot, urem, quot, rem;

    // Low 64 bits of the product of properly extended operands are exact for both signednesses.
    always_comb begin
        ext_a = (op_q == OpMult) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        ext_b = (op_q == OpMult) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        prod  = ext_a * ext_b;
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        div_signed = (op_q == OpDiv);
        neg_a      = div_signed & a_q[31];
        neg_b      = div_signed & b_q[31];
        mag_a      = neg_a ? -a_q : a_q;
        mag_b      = neg_b ? -b_q : b_q;
        uquot      = (mag_b != 32'd0) ? mag_a / mag_b : 32'd0;
        urem       = (mag_b != 32'd0) ? mag_a % mag_b : 32'd0;
        quot       = (neg_a ^ neg_b) ? -uquot : uquot;
        rem        = neg_a ? -urem : urem;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        case (op)
                            OpMult, OpMultu: begin
                                op_q    <= op;
                                a_q     <= srcA;
                                b_q     <= srcB;
                                cnt_q   <= MulCnt;
                                state_q <= StMul;
                            end
                            OpDiv, OpDivu: begin
                                op_q    <= op;
                                a_q     <= srcA;
                                b_q     <= srcB;
                                cnt_q   <= DivCnt;
                                state_q <= StDiv;
                            end
                            OpMthi:  hi_q <= srcA;
                            OpMtlo:  lo_q <= srcA;
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    if (cnt_q <= 5'd1) begin
                        hi_q    <= prod[63:32];
                        lo_q    <= prod[31:0];
                        cnt_q   <= 5'd0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                StDiv: begin
                    if (cnt_q <= 5'd1) begin
                        // Divide by zero burns the full latency but leaves HI/LO untouched.
                        if (b_q != 32'd0) begin
                            hi_q <= rem;
                            lo_q <= quot;
                        end
                        cnt_q   <= 5'd0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus randomized ops with
// busy-window interference, checked against a 64-bit arithmetic reference model.
module tb_mdu_ctrl;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA, srcB;
    logic        busy;
    logic [31:0] hi, lo;

    int          compared;
    int          mismatched;
    logic [31:0] hi_m, lo_m;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural effect of one accepted op.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp, sq, sr;
        longint unsigned up;
        case (o)
            3'd0: begin
                sp   = longint'($signed(a)) * longint'($signed(b));
                hi_m = sp[63:32];
                lo_m = sp[31:0];
            end
            3'd1: begin
                up   = longint'(a) * longint'(b);
                hi_m = up[63:32];
                lo_m = up[31:0];
            end
            3'd2: if (b != 32'd0) begin
                sq   = longint'($signed(a)) / longint'($signed(b));
                sr   = longint'($signed(a)) % longint'($signed(b));
                lo_m = sq[31:0];
                hi_m = sr[31:0];
            end
            3'd3: if (b != 32'd0) begin
                lo_m = a / b;
                hi_m = a % b;
            end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 9));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Called just after a falling edge; the op is presented for the next rising edge.
    // mode 0: random junk while busy, 1: MTHI spam while busy, 2: MULT spam while busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mode);
        int n;
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        n = (o <= 3'd1) ? int'(MULT_CYCLES) : (o <= 3'd3) ? int'(DIV_CYCLES) : 0;
        for (int i = 0; i < n; i++) begin
            check("busy_during_op", {31'b0, busy}, 32'd1);
            check("hi_hold", hi, hi_m);
            check("lo_hold", lo, lo_m);
            case (mode)
                1: begin start = 1'b1; op = 3'd4; srcA = $urandom; end
                2: begin start = 1'b1; op = 3'd0; srcA = $urandom; srcB = $urandom; end
                default: begin
                    start = 1'($urandom);
                    op    = 3'($urandom);
                    srcA  = $urandom;
                    srcB  = $urandom;
                end
            endcase
            @(negedge clk);
        end
        start = 1'b0;
        model_apply(o, a, b);
        check("busy_after_op", {31'b0, busy}, 32'd0);
        check("hi_result", hi, hi_m);
        check("lo_result", lo, lo_m);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        hi_m       = 32'd0;
        lo_m       = 32'd0;
        start      = 1'b0;
        op         = 3'd0;
        srcA       = 32'd0;
        srcB       = 32'd0;
        reset_n    = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
        check("mult_neg2x3_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg2x3_lo", lo, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_neg7_2_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd0, 0);
        check("divu_by0_lo", lo, 32'hFFFF_FFFD);
        check("divu_by0_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        run_op(3'd4, 32'h1234_5678, 32'd0, 0);
        check("mthi_idle", hi, 32'h1234_5678);
        run_op(3'd5, 32'hCAFE_F00D, 32'd0, 0);
        run_op(3'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        run_op(3'd3, 32'd100, 32'd0, 1);
        check("mthi_ignored_busy", hi, 32'h1234_5678);
        run_op(3'd2, 32'd100, 32'd7, 1);
        run_op(3'd0, 32'd6, 32'd7, 2);
        check("mult_spam_one_result", lo, 32'd42);
        run_op(3'd0, 32'd5, 32'd5, 2);
        check("second_after_busy", lo, 32'd25);

        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom), pick(), pick(), 0);
        end

        // Abort a divide with an asynchronous reset pulse mid-flight.
        start = 1'b1;
        op    = 3'd2;
        srcA  = 32'd1000;
        srcB  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < int'(DIV_CYCLES) + 2; i++) begin
            @(negedge clk);
            check("no_late_busy", {31'b0, busy}, 32'd0);
            check("no_late_hi", hi, 32'd0);
            check("no_late_lo", lo, 32'd0);
        end

        // Op presented before the first rising edge after reset release must be accepted.
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        run_op(3'd0, 32'd2, 32'd3, 0);
        check("mult_after_reset_lo", lo, 32'd6);
        check("mult_after_reset_hi", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
